// File: rtl/axi4_lite_pkg.sv
// Shared response codes and CTRL/STATUS bit positions for the AXI4-Lite register bank.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_DONE_CLR_BIT = 1;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;

endpackage

// File: rtl/axi4_lite_ctrl_status.sv
// Start/busy/done sequencing for the accelerator core behind the register bank.
module axi4_lite_ctrl_status (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_req_i,
    input  logic done_clr_i,
    input  logic done_i,
    output logic busy_o,
    output logic done_o,
    output logic start_o
);

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic start_q, start_d;

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        start_d = 1'b0;
        if (start_req_i && !busy_q) begin
            busy_d  = 1'b1;
            start_d = 1'b1;
        end
        if (done_clr_i) begin
            done_d = 1'b0;
        end
        // Completion is applied last so it beats a same-cycle clear.
        if (done_i && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign start_o = start_q;

endmodule

// File: rtl/axi4_lite_regbank_slave.sv
// AXI4-Lite slave: RW config registers, a CTRL/STATUS word and RO status words from the core.
module axi4_lite_regbank_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_RW       = 26,
    parameter int unsigned N_RO       = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_WIDTH-1:0]      S_AWADDR,
    input  logic                       S_AWVALID,
    output logic                       S_AWREADY,
    input  logic [DATA_WIDTH-1:0]      S_WDATA,
    input  logic [3:0]                 S_WSTRB,
    input  logic                       S_WVALID,
    output logic                       S_WREADY,
    output logic [1:0]                 S_BRESP,
    output logic                       S_BVALID,
    input  logic                       S_BREADY,
    input  logic [ADDR_WIDTH-1:0]      S_ARADDR,
    input  logic                       S_ARVALID,
    output logic                       S_ARREADY,
    output logic [DATA_WIDTH-1:0]      S_RDATA,
    output logic [1:0]                 S_RRESP,
    output logic                       S_RVALID,
    input  logic                       S_RREADY,
    output logic [N_RW*DATA_WIDTH-1:0] rw_regs_o,
    output logic                       start_o,
    input  logic                       done_i,
    input  logic [N_RO*DATA_WIDTH-1:0] ro_regs_i
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(N_RW);
    localparam logic [IDX_W-1:0] RO_LAST  = IDX_W'(N_RW + N_RO);

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [N_RW];
    logic [DATA_WIDTH-1:0] regs_d [N_RW];

    logic             commit;
    logic             start_req, done_clr;
    logic             busy, done;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    assign S_AWREADY = !aw_held_q && !bvalid_q;
    assign S_WREADY  = !w_held_q && !bvalid_q;
    assign S_ARREADY = !rvalid_q;
    assign commit    = aw_held_q && w_held_q;
    assign ar_idx    = S_ARADDR[ADDR_WIDTH-1:2];

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        start_req = 1'b0;
        done_clr  = 1'b0;
        if (S_AWVALID && S_AWREADY) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AWADDR[ADDR_WIDTH-1:2];
        end
        if (S_WVALID && S_WREADY) begin
            w_held_d = 1'b1;
            w_data_d = S_WDATA;
            w_strb_d = S_WSTRB;
        end
        if (bvalid_q && S_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            if (aw_idx_q < CTRL_IDX) begin
                for (int unsigned i = 0; i < N_RW; i++) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (aw_idx_q == IDX_W'(i) && w_strb_q[b]) begin
                            regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                        end
                    end
                end
            end else if (aw_idx_q == CTRL_IDX) begin
                if (w_strb_q[0]) begin
                    start_req = w_data_q[CTRL_START_BIT];
                    done_clr  = w_data_q[CTRL_DONE_CLR_BIT];
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (S_ARVALID && S_ARREADY) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            if (ar_idx < CTRL_IDX) begin
                for (int unsigned i = 0; i < N_RW; i++) begin
                    if (ar_idx == IDX_W'(i)) begin
                        rdata_d = regs_q[i];
                    end
                end
            end else if (ar_idx == CTRL_IDX) begin
                rdata_d[STAT_BUSY_BIT] = busy;
                rdata_d[STAT_DONE_BIT] = done;
            end else if (ar_idx <= RO_LAST) begin
                // First RO word sits in the top slice of ro_regs_i.
                for (int unsigned j = 0; j < N_RO; j++) begin
                    if (ar_idx == IDX_W'(N_RW + 1 + j)) begin
                        rdata_d = ro_regs_i[(N_RO-j)*DATA_WIDTH-1 -: DATA_WIDTH];
                    end
                end
            end else begin
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int unsigned i = 0; i < N_RW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign S_BVALID = bvalid_q;
    assign S_BRESP  = bresp_q;
    assign S_RVALID = rvalid_q;
    assign S_RDATA  = rdata_q;
    assign S_RRESP  = rresp_q;

    for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
        assign rw_regs_o[(N_RW-g)*DATA_WIDTH-1 -: DATA_WIDTH] = regs_q[g];
    end

    axi4_lite_ctrl_status u_ctrl_status (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .start_req_i (start_req),
        .done_clr_i  (done_clr),
        .done_i      (done_i),
        .busy_o      (busy),
        .done_o      (done),
        .start_o     (start_o)
    );

endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// Directed bench for the AXI4-Lite register bank with response scoreboards and a register model.
module tb_axi4_lite_regbank_slave;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NRW = 26;
    localparam int NRO = 2;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [AW-1:0]     S_AWADDR, S_ARADDR;
    logic              S_AWVALID, S_AWREADY, S_WVALID, S_WREADY;
    logic [DW-1:0]     S_WDATA, S_RDATA;
    logic [3:0]        S_WSTRB;
    logic [1:0]        S_BRESP, S_RRESP;
    logic              S_BVALID, S_BREADY, S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [NRW*DW-1:0] rw_regs;
    logic              start_o, done_i;
    logic [NRO*DW-1:0] ro_regs;

    int          total = 0;
    int          bad = 0;
    int          start_cnt = 0;
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    logic [31:0] model[NRW];

    axi4_lite_regbank_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_RW       (NRW),
        .N_RO       (NRO)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .rw_regs_o (rw_regs),
        .start_o   (start_o),
        .done_i    (done_i),
        .ro_regs_i (ro_regs)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (start_o === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NRW; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), {32'h0, rw_regs[(NRW-i)*DW-1 -: DW]},
                {32'h0, model[i]});
        end
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        while (S_BVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (S_BVALID !== 1'b1) begin
            chk({tag, "_b_timeout"}, {63'h0, S_BVALID}, 64'h1);
            if (exp_b_q.size() > 0) exp_b_q.pop_front();
        end else begin
            chk(tag, {62'h0, S_BRESP}, {62'h0, exp_b_q.pop_front()});
        end
    endtask

    task automatic wait_r(input string tag);
        int n = 0;
        while (S_RVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (S_RVALID !== 1'b1) begin
            chk({tag, "_r_timeout"}, {63'h0, S_RVALID}, 64'h1);
            if (exp_r_q.size() > 0) exp_r_q.pop_front();
        end else begin
            chk(tag, {30'h0, S_RRESP, S_RDATA}, {30'h0, exp_r_q.pop_front()});
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string tag);
        int   idx = int'(addr >> 2);
        int   n = 0;
        logic a, w;
        if (idx < NRW) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            exp_b_q.push_back(2'b00);
        end else if (idx == NRW) begin
            exp_b_q.push_back(2'b00);
        end else begin
            exp_b_q.push_back(2'b10);
        end
        S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b1;
        while ((S_AWVALID || S_WVALID) && n < 20) begin
            a = S_AWVALID && S_AWREADY;
            w = S_WVALID && S_WREADY;
            tick();
            if (a) S_AWVALID = 1'b0;
            if (w) S_WVALID = 1'b0;
            n++;
        end
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        wait_b(tag);
        tick();
        S_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        int n = 0;
        exp_r_q.push_back({exp_resp, exp_data});
        S_ARADDR = addr; S_ARVALID = 1'b1;
        while (S_ARVALID && n < 20) begin
            if (S_ARREADY) begin
                tick();
                S_ARVALID = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        S_ARVALID = 1'b0;
        wait_r(tag);
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1;
        S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
        S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0; done_i = 1'b0;
        ro_regs = {32'hAAAA0001, 32'hBBBB0002};
        for (int i = 0; i < NRW; i++) model[i] = '0;
        repeat (3) tick();
        ARESET = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", {61'h0, S_AWREADY, S_WREADY, S_ARREADY}, 64'h7);
        chk("rst_valid", {61'h0, S_BVALID, S_RVALID, start_o}, 64'h0);
        chk("rst_data", {28'h0, S_RDATA, S_RRESP, S_BRESP}, 64'h0);
        chk_regs("rst");

        // Full and partial byte-enable writes
        axi_write(32'h00, 32'hDEADBEEF, 4'b1111, "wr0_full_bresp");
        axi_read(32'h00, 32'hDEADBEEF, 2'b00, "rd0_full");
        chk("reg0_slice_full", {32'h0, rw_regs[NRW*DW-1 -: DW]}, {32'h0, 32'hDEADBEEF});
        axi_write(32'h00, 32'h12345678, 4'b0011, "wr0_strb_bresp");
        axi_read(32'h00, 32'hDEAD5678, 2'b00, "rd0_strb");
        chk("reg0_slice_strb", {32'h0, rw_regs[NRW*DW-1 -: DW]}, {32'h0, 32'hDEAD5678});

        // W three cycles ahead of AW, then BREADY held off
        exp_b_q.push_back(2'b00);
        model[1] = 32'hCAFEF00D;
        S_WDATA = 32'hCAFEF00D; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b0;
        tick();
        S_WVALID = 1'b0;
        chk("wready_drop", {63'h0, S_WREADY}, 64'h0);
        tick();
        tick();
        S_AWADDR = 32'h04; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        chk("bvalid_not_yet", {63'h0, S_BVALID}, 64'h0);
        tick();
        chk("bvalid_one_after_aw", {63'h0, S_BVALID}, 64'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("b_stall%0d", k), {61'h0, S_BVALID, S_BRESP}, 64'h4);
        end
        wait_b("w_first_bresp");
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        chk("bvalid_released", {63'h0, S_BVALID}, 64'h0);
        chk("reg1_slice", {32'h0, rw_regs[(NRW-1)*DW-1 -: DW]}, {32'h0, 32'hCAFEF00D});

        // Start / busy / done
        axi_write(32'h68, 32'h1, 4'hF, "ctrl_start_bresp");
        tick();
        chk("start_pulse_once", 64'(start_cnt), 64'd1);
        axi_read(32'h68, 32'h1, 2'b00, "ctrl_busy");
        axi_write(32'h68, 32'h1, 4'hF, "ctrl_restart_bresp");
        tick();
        chk("no_restart_pulse", 64'(start_cnt), 64'd1);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        axi_read(32'h68, 32'h2, 2'b00, "ctrl_done");
        axi_write(32'h68, 32'h2, 4'hF, "ctrl_clr_bresp");
        axi_read(32'h68, 32'h0, 2'b00, "ctrl_cleared");

        // Read-only words
        axi_read(32'h6C, 32'hAAAA0001, 2'b00, "ro0");
        axi_read(32'h70, 32'hBBBB0002, 2'b00, "ro1");
        axi_write(32'h6C, 32'h11111111, 4'hF, "ro_wr_bresp");
        axi_read(32'h6C, 32'hAAAA0001, 2'b00, "ro0_after_wr");

        // Unmapped address
        axi_read(32'h100, 32'h0, 2'b10, "unmapped_rd");
        axi_write(32'h100, 32'hFFFFFFFF, 4'hF, "unmapped_wr_bresp");
        chk_regs("after_unmapped");

        // Reset with both responses pending
        S_AWADDR = 32'h0C; S_WDATA = 32'h77777777; S_WSTRB = 4'hF;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARADDR = 32'h00; S_ARVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        tick();
        tick();
        chk("pre_reset_valids", {62'h0, S_BVALID, S_RVALID}, 64'h3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < NRW; i++) model[i] = '0;
        chk("post_reset_valids", {62'h0, S_BVALID, S_RVALID}, 64'h0);
        chk("post_reset_ready", {61'h0, S_AWREADY, S_WREADY, S_ARREADY}, 64'h7);
        chk_regs("post_reset");

        // Same-cycle read and write of reg 2
        exp_r_q.push_back({2'b00, 32'h0});
        exp_b_q.push_back(2'b00);
        S_AWADDR = 32'h08; S_WDATA = 32'h00000055; S_WSTRB = 4'hF; S_ARADDR = 32'h08;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1; S_BREADY = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        wait_r("same_cycle_rd_old");
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
        wait_b("same_cycle_bresp");
        tick();
        S_BREADY = 1'b0;
        model[2] = 32'h00000055;
        axi_read(32'h08, 32'h00000055, 2'b00, "reg2_new");
        chk_regs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regbank_slave.md
Name: axi4_lite_regbank_slave

Overview:
Parametrised AXI4-Lite slave register bank, the next-generation host interface for accelerator cores such as the FCN.
- Provides N_RW read/write configuration registers, one control/status register with a start pulse and a sticky done flag, and N_RO read-only status registers sampled from the core.
- Read and write channels run independently and concurrently.
- Supports WSTRB byte enables and SLVERR for unmapped addresses.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; must be 32 (WSTRB is 4 bits)
N_RW, 26, number of read/write registers (word indices 0..N_RW-1)
N_RO, 2, number of read-only registers (word indices N_RW+1..N_RW+N_RO)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AWADDR  in  ADDR_WIDTH  write address
S_AWVALID  in  1  write address valid
S_AWREADY  out  1  write address ready
S_WDATA  in  DATA_WIDTH  write data
S_WSTRB  in  4  byte enables
S_WVALID  in  1  write data valid
S_WREADY  out  1  write data ready
S_BRESP  out  2  write response
S_BVALID  out  1  write response valid
S_BREADY  in  1  write response ready
S_ARADDR  in  ADDR_WIDTH  read address
S_ARVALID  in  1  read address valid
S_ARREADY  out  1  read address ready
S_RDATA  out  DATA_WIDTH  read data
S_RRESP  out  2  read response
S_RVALID  out  1  read data valid
S_RREADY  in  1  read data ready
rw_regs_o  out  N_RW*DATA_WIDTH  RW registers flattened; register 0 in the most-significant slice
start_o  out  1  one-cycle start pulse to core
done_i  in  1  core completion (level or pulse)
ro_regs_i  in  N_RO*DATA_WIDTH  core status words; RO index N_RW+1 in the most-significant slice

Behaviour:
- Reset (ARESET high at a rising ACLK edge): all registers 0; busy=0, done=0; start_o=0; BVALID=RVALID=0; AWREADY=WREADY=ARREADY=1; RDATA=0; BRESP=RRESP=0. Reset aborts any transaction in flight; no response is issued for it.
- Word index = ADDR[ADDR_WIDTH-1:2]. ADDR[1:0] is ignored.
- Write path:
  - AW and W are each accepted independently, in either order or in the same cycle, into holding registers. AWREADY is low while AW is held or BVALID is high; WREADY likewise for W.
  - The cycle after both are held: commit the write, assert BVALID, clear both holds.
  - BVALID stays high until the BREADY handshake. Minimum latency from simultaneous AW+W handshake to BVALID is 1 cycle.
  - Commit to an RW index: byte k is updated only where WSTRB[k]=1. BRESP=OKAY (00).
  - Commit to the CTRL index (N_RW), gated by WSTRB[0]:
    - bit0=1 while busy=0: start_o=1 for exactly the next cycle, busy<=1.
    - bit0=1 while busy=1: ignored.
    - bit1=1: clears done.
    - BRESP=OKAY.
  - Commit to an RO index or an unmapped index (>N_RW+N_RO): no state change, BRESP=SLVERR (10).
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake, RDATA/RRESP are registered and RVALID=1 on the next cycle, held stable until the RREADY handshake. Back-to-back reads are separated by at least one cycle with RVALID high.
  - RW index returns the register value.
  - CTRL returns {30'b0, done, busy}.
  - RO index returns ro_regs_i sampled at the AR handshake.
  - Unmapped index returns 0 with RRESP=SLVERR.
- Status:
  - A rising ACLK edge with done_i=1 and busy=1 sets done=1 and clears busy.
  - done_i while busy=0 is ignored.
  - If done_i sets done and a bit1 clear commits in the same cycle, set wins: done=1.
- Read and write in the same cycle to the same RW index: the read returns the pre-write value.
- rw_regs_o reflects committed register values combinationally from the flops (no extra latency).

Decomposition:
- Package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - CTRL_START_BIT=0, CTRL_DONE_CLR_BIT=1
  - STAT_BUSY_BIT=0, STAT_DONE_BIT=1
- Sub-module axi4_lite_ctrl_status owns busy/done/start_o, with inputs start_req, done_clr, done_i. The main module owns the channel handshakes, address decode and register array.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x00 with WSTRB=1111, then WSTRB=0011 write of 0x12345678 to 0x00 -> BRESP=00 both times; read 0x00 returns 0xDEADBEEF, then 0xDEAD5678; rw_regs_o MSB slice matches.
- W presented 3 cycles before AW to addr 0x04 -> WREADY drops after W accepted; BVALID 1 cycle after AW handshake; reg1 updated; BREADY held low 5 cycles keeps BVALID and BRESP stable.
- Write 0x1 to CTRL (addr 4*N_RW=0x68) -> start_o high exactly 1 cycle; CTRL read=0x1. Second start while busy -> no pulse. done_i pulse -> CTRL read=0x2. Write 0x2 -> CTRL read=0x0.
- ro_regs_i = {0xAAAA0001, 0xBBBB0002}, read 0x6C and 0x70 -> 0xAAAA0001, 0xBBBB0002, RRESP=00. Write to 0x6C -> BRESP=10, value unchanged.
- Read and write to unmapped addr 0x100 -> RRESP=10 with RDATA=0; BRESP=10; no register changes.
- Assert ARESET while BVALID=1 and RVALID=1 -> both low next cycle, all registers 0, READYs high; then simultaneous read/write to reg 2 -> read returns old value 0.
